fifo_tx_drain: RTL and testbench

FIFO_TX_DRAIN -- requirements
Module: fifo_tx_drain

---
 rtl/fifo_tx_drain.sv | 103 ++++++++++
 tb/tb_fifo_tx_drain.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/fifo_tx_drain.sv
// Drains a show-ahead FIFO onto a UART-style serial line: start bit, DATA_W
// data bits LSB first, stop bit, each CLKS_PER_BIT clocks long.
module fifo_tx_drain #(
  parameter int CLKS_PER_BIT = 4,
  parameter int DATA_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              empty,
  input  logic [DATA_W-1:0] data_pop,
  output logic              pop,
  output logic              tx,
  output logic              busy,
  output logic              byte_done,
  output logic [7:0]        bytes_sent
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam int            IW       = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [7:0]    LAST_CNT = 8'(CLKS_PER_BIT - 1);
  localparam logic [7:0]    PRE_CNT  = 8'(CLKS_PER_BIT - 2);
  localparam logic [IW-1:0] LAST_BIT = IW'(DATA_W - 1);

  state_t            state;
  logic [7:0]        cnt;
  logic [IW-1:0]     bit_idx;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] sh_next;
  logic              bit_end;

  assign sh_next = shreg >> 1;
  assign bit_end = (cnt == LAST_CNT);
  assign pop     = (state == IDLE) && enable && !empty && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      byte_done  <= 1'b0;
      bytes_sent <= '0;
    end else begin
      byte_done <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            shreg   <= data_pop;
            state   <= START;
            cnt     <= '0;
            bit_idx <= '0;
            tx      <= 1'b0;
            busy    <= 1'b1;
          end
        end
        START: begin
          if (bit_end) begin
            cnt   <= '0;
            state <= DATA;
            tx    <= shreg[0];
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        DATA: begin
          if (bit_end) begin
            cnt   <= '0;
            shreg <= sh_next;
            if (bit_idx == LAST_BIT) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              tx      <= sh_next[0];
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        STOP: begin
          // Registered pulse must be launched one cycle early to land on the last stop cycle.
          if (cnt == PRE_CNT) begin
            byte_done  <= 1'b1;
            bytes_sent <= bytes_sent + 8'd1;
          end
          if (bit_end) begin
            cnt   <= '0;
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_tx_drain.sv
// Directed bench for fifo_tx_drain (CLKS_PER_BIT=4, DATA_W=8) with a small
// show-ahead FIFO model feeding the DUT; outputs sampled on the falling edge.
module tb_fifo_tx_drain;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       empty;
  logic [7:0] data_pop;
  logic       pop, tx, busy, byte_done;
  logic [7:0] bytes_sent;

  logic [7:0]  mem [0:1023];
  logic [31:0] rd_ptr = 0;
  logic [31:0] wr_ptr = 0;
  int n_cmp = 0;
  int n_err = 0;

  fifo_tx_drain #(.CLKS_PER_BIT(4), .DATA_W(8)) dut (
    .clk(clk), .rst(rst), .enable(enable), .empty(empty), .data_pop(data_pop),
    .pop(pop), .tx(tx), .busy(busy), .byte_done(byte_done), .bytes_sent(bytes_sent)
  );

  always #5 clk = ~clk;

  assign empty    = (rd_ptr == wr_ptr);
  assign data_pop = mem[rd_ptr[9:0]];
  always @(posedge clk) if (pop) rd_ptr <= rd_ptr + 1;

  task automatic push(input logic [7:0] b);
    mem[wr_ptr[9:0]] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b1;
    push(8'hA5);
    repeat (3) @(negedge clk);
    n_cmp++; if (tx !== 1'b1) begin n_err++; $display("FAIL reset_tx: got %b want 1", tx); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (byte_done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", byte_done); end
    n_cmp++; if (bytes_sent !== 8'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", bytes_sent); end
    n_cmp++; if (pop !== 1'b0) begin n_err++; $display("FAIL reset_pop: got %b want 0", pop); end
    wr_ptr = rd_ptr;
    rst = 1'b0;
  endtask

  task automatic test_single();
    logic [9:0] fr;
    fr = {1'b1, 8'h05, 1'b0};
    @(negedge clk);
    enable = 1'b1;
    push(8'h05);
    #1;
    n_cmp++; if (pop !== 1'b1) begin n_err++; $display("FAIL single_pop: got %b want 1", pop); end
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      n_cmp++; if (tx !== fr[(k-1)/4]) begin n_err++; $display("FAIL single_tx c%0d: got %b want %b", k, tx, fr[(k-1)/4]); end
      n_cmp++; if (byte_done !== (k == 40)) begin n_err++; $display("FAIL single_done c%0d: got %b want %b", k, byte_done, (k == 40)); end
      n_cmp++; if (pop !== 1'b0) begin n_err++; $display("FAIL single_pop_once c%0d: got %b want 0", k, pop); end
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy c%0d: got %b want 1", k, busy); end
    end
    n_cmp++; if (bytes_sent !== 8'd1) begin n_err++; $display("FAIL single_count: got %0d want 1", bytes_sent); end
  endtask

  task automatic test_back_to_back();
    logic [9:0] fr1, fr2;
    fr1 = {1'b1, 8'h05, 1'b0};
    fr2 = {1'b1, 8'h08, 1'b0};
    @(negedge clk);
    do_reset();
    push(8'h05); push(8'h08);
    #1;
    n_cmp++; if (pop !== 1'b1) begin n_err++; $display("FAIL b2b_pop1: got %b want 1", pop); end
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      n_cmp++; if (tx !== fr1[(k-1)/4]) begin n_err++; $display("FAIL b2b_tx1 c%0d: got %b want %b", k, tx, fr1[(k-1)/4]); end
      n_cmp++; if (byte_done !== (k == 40)) begin n_err++; $display("FAIL b2b_done1 c%0d: got %b want %b", k, byte_done, (k == 40)); end
    end
    @(negedge clk);
    n_cmp++; if (pop !== 1'b1) begin n_err++; $display("FAIL b2b_pop2: got %b want 1", pop); end
    n_cmp++; if (tx !== 1'b1) begin n_err++; $display("FAIL b2b_idle_tx: got %b want 1", tx); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_idle_busy: got %b want 0", busy); end
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      n_cmp++; if (tx !== fr2[(k-1)/4]) begin n_err++; $display("FAIL b2b_tx2 c%0d: got %b want %b", k, tx, fr2[(k-1)/4]); end
      n_cmp++; if (byte_done !== (k == 40)) begin n_err++; $display("FAIL b2b_done2 c%0d: got %b want %b", k, byte_done, (k == 40)); end
    end
    n_cmp++; if (bytes_sent !== 8'd2) begin n_err++; $display("FAIL b2b_count: got %0d want 2", bytes_sent); end
  endtask

  task automatic test_empty();
    @(negedge clk);
    enable = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      n_cmp++; if (pop !== 1'b0) begin n_err++; $display("FAIL empty_pop c%0d: got %b want 0", k, pop); end
      n_cmp++; if (tx !== 1'b1) begin n_err++; $display("FAIL empty_tx c%0d: got %b want 1", k, tx); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL empty_busy c%0d: got %b want 0", k, busy); end
    end
  endtask

  task automatic test_enable_drop();
    logic [9:0] fr;
    fr = {1'b1, 8'h03, 1'b0};
    @(negedge clk);
    push(8'h03);
    #1;
    n_cmp++; if (pop !== 1'b1) begin n_err++; $display("FAIL endrop_pop: got %b want 1", pop); end
    for (int k = 1; k <= 45; k++) begin
      @(negedge clk);
      n_cmp++; if (tx !== ((k <= 40) ? fr[(k-1)/4] : 1'b1)) begin n_err++; $display("FAIL endrop_tx c%0d: got %b", k, tx); end
      n_cmp++; if (byte_done !== (k == 40)) begin n_err++; $display("FAIL endrop_done c%0d: got %b want %b", k, byte_done, (k == 40)); end
      n_cmp++; if (pop !== 1'b0) begin n_err++; $display("FAIL endrop_nopop c%0d: got %b want 0", k, pop); end
      if (k == 10) enable = 1'b0;
      if (k == 12) push(8'h44);
    end
    n_cmp++; if (bytes_sent !== 8'd3) begin n_err++; $display("FAIL endrop_count: got %0d want 3", bytes_sent); end
    enable = 1'b1;
    #1;
    n_cmp++; if (pop !== 1'b1) begin n_err++; $display("FAIL endrop_repop: got %b want 1", pop); end
  endtask

  // Continues from the 0x44 pop issued at the end of test_enable_drop.
  task automatic test_reset_mid();
    logic [9:0] fr;
    fr = {1'b1, 8'h5A, 1'b0};
    repeat (10) @(negedge clk);
    rst = 1'b1;
    push(8'h5A);
    @(negedge clk);
    n_cmp++; if (tx !== 1'b1) begin n_err++; $display("FAIL rmid_tx: got %b want 1", tx); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rmid_busy: got %b want 0", busy); end
    n_cmp++; if (bytes_sent !== 8'd0) begin n_err++; $display("FAIL rmid_count: got %0d want 0", bytes_sent); end
    n_cmp++; if (pop !== 1'b0) begin n_err++; $display("FAIL rmid_pop_in_rst: got %b want 0", pop); end
    rst = 1'b0;
    #1;
    n_cmp++; if (pop !== 1'b1) begin n_err++; $display("FAIL rmid_pop_after: got %b want 1", pop); end
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      n_cmp++; if (tx !== fr[(k-1)/4]) begin n_err++; $display("FAIL rmid_tx c%0d: got %b want %b", k, tx, fr[(k-1)/4]); end
      n_cmp++; if (byte_done !== (k == 40)) begin n_err++; $display("FAIL rmid_done c%0d: got %b want %b", k, byte_done, (k == 40)); end
    end
    n_cmp++; if (bytes_sent !== 8'd1) begin n_err++; $display("FAIL rmid_count_after: got %0d want 1", bytes_sent); end
  endtask

  task automatic test_wrap();
    int pulses;
    pulses = 0;
    @(negedge clk);
    do_reset();
    for (int i = 0; i < 256; i++) push(8'(i));
    for (int c = 0; c < 256 * 41 + 50 && pulses < 256; c++) begin
      @(negedge clk);
      if (byte_done === 1'b1) begin
        pulses++;
        if (pulses == 255) begin
          n_cmp++; if (bytes_sent !== 8'd255) begin n_err++; $display("FAIL wrap_255: got %0d want 255", bytes_sent); end
        end
        if (pulses == 256) begin
          n_cmp++; if (bytes_sent !== 8'd0) begin n_err++; $display("FAIL wrap_0: got %0d want 0", bytes_sent); end
        end
      end
    end
    n_cmp++; if (pulses != 256) begin n_err++; $display("FAIL wrap_frames: got %0d want 256", pulses); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_empty();
    test_enable_drop();
    test_reset_mid();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
